rx_demapper: RTL and testbench
==============================

Name: rx_demapper

Overview:
Receive-side counterpart of the DAC TX lane mapper. Takes two 128-bit JESD RX lane words (8 lanes × 32 bit, byte-split samples) from the ADC link. Rebuilds four converters × four 16-bit samples into one 256-bit word and delivers it on a valid/ready stream to the capture DMA. Small show-ahead FIFO absorbs downstream backpressure; drops are counted.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
CNT_W, 16, width of drop counter

Ports:
clk  in  1  link-side clock
rst  in  1  synchronous, active-high reset
data_in0  in  128  lanes 3..0, {lane3,lane2,lane1,lane0}
data_in1  in  128  lanes 7..4, {lane7,lane6,lane5,lane4}
data_in_valid  in  1  lane words valid this cycle (no backpressure upstream)
rx_enable  in  1  accept input when high
data_out  out  256  {adc0[255:192], adc1[191:128], adc2[127:64], adc3[63:0]}
data_out_valid  out  1  head of FIFO valid
data_out_ready  in  1  downstream accepts
stats_clear  in  1  clears drop_count and overflow
drop_count  out  CNT_W  words dropped on full FIFO, saturating
overflow  out  1  sticky, set on any drop
adc0_sample0_ila..adc3_sample0_ila  out  16 each  stage-1 sample 0 per converter

Behaviour:
- Reset (rst high at clk edge): FIFO empty, stage-1 valid=0, data_out_valid=0, data_out=0, drop_count=0, overflow=0, ILA outputs=0.
- Lane map: lane 2c carries the MSBs and lane 2c+1 the LSBs of converter c (c=0..3). Byte k (bits 8k+7:8k) holds sample k.
- Reconstruction: adc_c sample k = {lane2c[8k+7:8k], lane2c+1[8k+7:8k]}. In the converter slot, sample k sits at bits 16k+15:16k, so sample 0 is lowest.
- Stage 1: registered. Captures the reconstructed word when data_in_valid & rx_enable. s1_valid follows that condition each cycle. ILA outputs update from stage 1.
- FIFO: first-word fall-through. data_out = mem[rd_ptr], data_out_valid = (count≠0). Pop on data_out_valid & data_out_ready.
- Write: s1_valid & (not full, or pop in the same cycle). Simultaneous push and pop when full is legal; count is unchanged.
- Latency: input at edge N → data_out_valid high after edge N+1 (2 cycles), FIFO empty case.
- Drop: s1_valid & full & no pop. The word is discarded, drop_count += 1 (saturates at all-ones), overflow=1.
- stats_clear: drop_count=0, overflow=0. A drop in the same cycle wins: drop_count=1, overflow=1.
- rx_enable low: no new captures. FIFO continues to drain normally.
- Pointers wrap modulo FIFO_DEPTH. count is clog2(FIFO_DEPTH)+1 bits.
- data_out holds stable while valid & !ready.

Decomposition:
- Shared package/header: SAMPLE_W=16, LANE_W=32, N_CONV=4, SAMPLES_PER_CONV=4, LANES_PER_CONV=2, and the slot offset constants for the 256-bit word. The TX mapper uses the same package.
- One sub-module: sync_fifo_fwft. Parameters WIDTH and DEPTH; ports clk, rst, push, pop, full, empty, dout, count.
- Deinterleave stays inline in rx_demapper.

Test Plan:
- ADC0 samples 0x1122, 0x3344, 0x5566, 0x7788, others 0. Stimulus: data_in0 = 128'h0_0_88664422_77553311, data_in1 = 0, valid for 1 cycle, ready=1. Required: data_out[255:192] = 64'h7788_5566_3344_1122, rest 0, valid exactly 1 cycle, 2 cycles after input. adc0_sample0_ila = 16'h1122.
- Incrementing pattern on all 8 lanes, 100 back-to-back words, ready=1. Required: output equals the software inverse of the TX mapping and no bubbles after the first 2 cycles; drop_count = 0.
- ready=0, feed 6 words with FIFO_DEPTH=4. Required: first 4 words retained in order, drop_count = 2, overflow = 1. Releasing ready drains exactly words 1..4.
- FIFO full with ready=1 and a new valid input in the same cycle. Required: push and pop both occur, drop_count unchanged.
- Drop in the same cycle as stats_clear. Required: drop_count = 1, overflow = 1. stats_clear alone next cycle gives 0/0.
- rst asserted mid-stream with 3 words queued. Required: next cycle data_out_valid = 0, data_out = 0, counters 0. Words sent after rst deassert appear with 2-cycle latency.

Source files
------------

// File: rtl/rx_demapper_pkg.sv
// rx_demapper_pkg: sample/lane geometry shared by the RX demapper and the TX mapper.
package rx_demapper_pkg;
  localparam int SAMPLE_W = 16;
  localparam int LANE_W = 32;
  localparam int N_CONV = 4;
  localparam int SAMPLES_PER_CONV = 4;
  localparam int LANES_PER_CONV = 2;
  localparam int BYTE_W = SAMPLE_W / 2;
  localparam int N_LANES = N_CONV * LANES_PER_CONV;
  localparam int CONV_W = SAMPLE_W * SAMPLES_PER_CONV;
  localparam int WORD_W = CONV_W * N_CONV;
  localparam int ADC0_LO = 3 * CONV_W;
  localparam int ADC1_LO = 2 * CONV_W;
  localparam int ADC2_LO = CONV_W;
  localparam int ADC3_LO = 0;
  // converter 0 owns the top slot of the output word
  function automatic int slot_lo(input int c);
    return (N_CONV - 1 - c) * CONV_W;
  endfunction
endpackage

// File: rtl/rx_demapper_fifo.sv
// sync_fifo_fwft: show-ahead synchronous FIFO; dout reads zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/rx_demapper.sv
// rx_demapper: rebuild byte-split JESD lanes into a 256-bit converter word and stream it out.
module rx_demapper
  import rx_demapper_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [127:0]        data_in0,
  input  logic [127:0]        data_in1,
  input  logic                data_in_valid,
  input  logic                rx_enable,
  output logic [255:0]        data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  input  logic                stats_clear,
  output logic [CNT_W-1:0]    drop_count,
  output logic                overflow,
  output logic [15:0]         adc0_sample0_ila,
  output logic [15:0]         adc1_sample0_ila,
  output logic [15:0]         adc2_sample0_ila,
  output logic [15:0]         adc3_sample0_ila
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [N_LANES*LANE_W-1:0] lanes;
  logic [WORD_W-1:0] word, s1_data;
  logic s1_valid, full, empty, push, pop, drop;
  logic [CW-1:0] count;
  assign lanes = {data_in1, data_in0};
  // even lane of a pair carries the sample MSBs, odd lane the LSBs
  always_comb begin
    word = '0;
    for (int c = 0; c < N_CONV; c++)
      for (int k = 0; k < SAMPLES_PER_CONV; k++)
        word[slot_lo(c) + SAMPLE_W*k +: SAMPLE_W] =
          {lanes[LANE_W*LANES_PER_CONV*c + BYTE_W*k +: BYTE_W],
           lanes[LANE_W*(LANES_PER_CONV*c + 1) + BYTE_W*k +: BYTE_W]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_valid <= data_in_valid & rx_enable;
      if (data_in_valid & rx_enable) s1_data <= word;
    end
  end
  assign pop = !empty & data_out_ready;
  assign push = s1_valid & (!full | pop);
  assign drop = s1_valid & full & !pop;
  assign data_out_valid = count != '0;
  sync_fifo_fwft #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(s1_data),
    .full(full), .empty(empty), .dout(data_out), .count(count)
  );
  // a drop coinciding with a clear leaves a count of one
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      drop_count <= stats_clear ? CNT_W'(1) : (&drop_count ? drop_count : drop_count + 1'b1);
      overflow <= 1'b1;
    end else if (stats_clear) begin
      drop_count <= '0;
      overflow <= 1'b0;
    end
  end
  assign adc0_sample0_ila = s1_data[ADC0_LO +: SAMPLE_W];
  assign adc1_sample0_ila = s1_data[ADC1_LO +: SAMPLE_W];
  assign adc2_sample0_ila = s1_data[ADC2_LO +: SAMPLE_W];
  assign adc3_sample0_ila = s1_data[ADC3_LO +: SAMPLE_W];
endmodule

// File: tb/tb_rx_demapper.sv
// tb_rx_demapper: cycle scoreboard for rx_demapper built from a forward TX lane mapping.
module tb_rx_demapper;
  logic clk = 1'b0;
  logic rst = 1'b1, data_in_valid = 1'b0, rx_enable = 1'b1, data_out_ready = 1'b1, stats_clear = 1'b0;
  logic [127:0] data_in0 = '0, data_in1 = '0;
  logic [255:0] data_out;
  logic data_out_valid, overflow;
  logic [15:0] drop_count, ila0, ila1, ila2, ila3;
  always #5 clk = ~clk;
  rx_demapper #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_in0(data_in0), .data_in1(data_in1),
    .data_in_valid(data_in_valid), .rx_enable(rx_enable), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .stats_clear(stats_clear), .drop_count(drop_count), .overflow(overflow),
    .adc0_sample0_ila(ila0), .adc1_sample0_ila(ila1),
    .adc2_sample0_ila(ila2), .adc3_sample0_ila(ila3)
  );
  int errs = 0, checks = 0, seq = 0;
  logic [15:0] smp [4][4];
  logic [255:0] cur_exp = '0, m_s1 = '0;
  logic m_s1v = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_drops = '0;
  logic [255:0] q [$];
  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  // forward TX mapping: sample k of converter c split across lanes 2c/2c+1, byte k
  task automatic load();
    logic [255:0] l;
    l = '0;
    cur_exp = '0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        l[64*c + 8*k +: 8] = smp[c][k][15:8];
        l[64*c + 32 + 8*k +: 8] = smp[c][k][7:0];
        cur_exp[(3-c)*64 + 16*k +: 16] = smp[c][k];
      end
    {data_in1, data_in0} = l;
  endtask
  task automatic cycle();
    logic pop, full, push, drop;
    chk("valid", data_out_valid, q.size() != 0);
    if (q.size() != 0) chk("data", data_out, q[0]);
    else chk("data_idle", data_out, '0);
    chk("drops", drop_count, m_drops);
    chk("ovf", overflow, m_ovf);
    chk("ila0", ila0, m_s1[192 +: 16]);
    chk("ila1", ila1, m_s1[128 +: 16]);
    chk("ila2", ila2, m_s1[64 +: 16]);
    chk("ila3", ila3, m_s1[0 +: 16]);
    if (rst) begin
      q.delete();
      m_s1v = 1'b0;
      m_s1 = '0;
      m_drops = '0;
      m_ovf = 1'b0;
    end else begin
      pop = q.size() != 0 && data_out_ready;
      full = q.size() == 4;
      push = m_s1v && (!full || pop);
      drop = m_s1v && full && !pop;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(m_s1);
      if (drop) begin
        m_drops = stats_clear ? 16'd1 : (m_drops == 16'hffff ? m_drops : m_drops + 16'd1);
        m_ovf = 1'b1;
      end else if (stats_clear) begin
        m_drops = '0;
        m_ovf = 1'b0;
      end
      m_s1v = data_in_valid && rx_enable;
      if (m_s1v) m_s1 = cur_exp;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input int n, input bit incr);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++)
          smp[c][k] = incr ? 16'((seq*16 + c*4 + k) * 'h0101) : 16'($urandom);
      seq++;
      load();
      data_in_valid = 1'b1;
      cycle();
    end
    data_in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    idle(1);
    // single converter-0 word with known lane image
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) smp[c][k] = '0;
    smp[0][0] = 16'h1122; smp[0][1] = 16'h3344; smp[0][2] = 16'h5566; smp[0][3] = 16'h7788;
    load();
    data_in_valid = 1'b1;
    cycle();
    data_in_valid = 1'b0;
    chk("t1_ila0", ila0, 16'h1122);
    chk("t1_lat1", data_out_valid, 1'b0);
    cycle();
    chk("t1_lat2", data_out_valid, 1'b1);
    chk("t1_word", data_out, {64'h7788_5566_3344_1122, 192'h0});
    idle(3);
    // back-to-back incrementing stream
    send(100, 1'b1);
    idle(3);
    chk("t2_drops", drop_count, 16'd0);
    // overflow with ready held low
    data_out_ready = 1'b0;
    send(6, 1'b0);
    idle(1);
    chk("t3_drops", drop_count, 16'd2);
    chk("t3_ovf", overflow, 1'b1);
    // drop coinciding with clear
    send(1, 1'b0);
    stats_clear = 1'b1;
    cycle();
    stats_clear = 1'b0;
    chk("t5_drops", drop_count, 16'd1);
    chk("t5_ovf", overflow, 1'b1);
    stats_clear = 1'b1;
    cycle();
    stats_clear = 1'b0;
    chk("t5_clr_drops", drop_count, 16'd0);
    chk("t5_clr_ovf", overflow, 1'b0);
    data_out_ready = 1'b1;
    idle(6);
    // full FIFO with simultaneous push and pop
    data_out_ready = 1'b0;
    send(5, 1'b0);
    data_out_ready = 1'b1;
    cycle();
    chk("t4_drops", drop_count, 16'd0);
    idle(6);
    // enable low: no capture while the FIFO drains
    data_out_ready = 1'b0;
    send(2, 1'b0);
    data_out_ready = 1'b1;
    rx_enable = 1'b0;
    send(4, 1'b0);
    rx_enable = 1'b1;
    idle(3);
    // reset mid-stream with words queued
    data_out_ready = 1'b0;
    send(4, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_valid", data_out_valid, 1'b0);
    chk("t6_data", data_out, '0);
    chk("t6_drops", drop_count, 16'd0);
    data_out_ready = 1'b1;
    send(3, 1'b0);
    idle(3);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) smp[c][k] = 16'($urandom);
      load();
      data_in_valid = 1'($urandom_range(0, 3) != 0);
      rx_enable = 1'($urandom_range(0, 7) != 0);
      data_out_ready = 1'($urandom_range(0, 1));
      stats_clear = 1'($urandom_range(0, 15) == 0);
      cycle();
    end
    data_in_valid = 1'b0;
    stats_clear = 1'b0;
    rx_enable = 1'b1;
    data_out_ready = 1'b1;
    idle(8);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
